// File: rtl/musicbox_pkg.sv
// Shared definitions for the music box sequencer.
// Holds the FSM state type, the special note codes, the field layout of a song
// ROM entry and the octave-0 half-period table builder used by note_div_lut.
package musicbox_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD,
    PLAY
  } state_t;

  localparam logic [6:0] NOTE_REST = 7'h00;
  localparam logic [6:0] NOTE_END  = 7'h7F;

  // ROM entry layout: {dur[3:0], note[6:0]}, note = {oct[2:0], semi[3:0]}
  localparam int ENTRY_W   = 11;
  localparam int NOTE_LSB  = 0;
  localparam int NOTE_W    = 7;
  localparam int DUR_LSB   = 7;
  localparam int DUR_W     = 4;
  localparam int SEMI_W    = 4;
  localparam int OCT_W     = 3;
  localparam int NUM_SEMIS = 12;

  // Half-period clock count for semitone 'semi' of octave 0, rounded to nearest.
  // Frequencies are equal temperament around A0 = 27.5 Hz, held in micro-hertz
  // so the whole computation stays in integer arithmetic at elaboration time.
  function automatic longint unsigned base_div(input int semi, input longint unsigned clk_hz);
    longint unsigned f_uhz;
    case (semi)
      0:       f_uhz = 64'd16351598;
      1:       f_uhz = 64'd17323914;
      2:       f_uhz = 64'd18354048;
      3:       f_uhz = 64'd19445436;
      4:       f_uhz = 64'd20601722;
      5:       f_uhz = 64'd21826764;
      6:       f_uhz = 64'd23124651;
      7:       f_uhz = 64'd24499715;
      8:       f_uhz = 64'd25956544;
      9:       f_uhz = 64'd27500000;
      10:      f_uhz = 64'd29135235;
      default: f_uhz = 64'd30867706;
    endcase
    return (clk_hz * 64'd1000000 + f_uhz) / (64'd2 * f_uhz);
  endfunction

endpackage

// File: rtl/musicbox_if.sv
// Bus between the sequencer and its surroundings (control, song ROM, tone
// generator, beat LED).
//   master (sequencer): in  start, stop, loop_en, rom_data
//                       out rom_addr, tone_div, tone_en, busy, done, led
//   slave  (system):    the mirror image of master
interface musicbox_if
  import musicbox_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DIV_W  = 20
);

  logic               start;
  logic               stop;
  logic               loop_en;
  logic [ADDR_W-1:0]  rom_addr;
  logic [ENTRY_W-1:0] rom_data;
  logic [DIV_W-1:0]   tone_div;
  logic               tone_en;
  logic               busy;
  logic               done;
  logic               led;

  modport master (
    input  start, stop, loop_en, rom_data,
    output rom_addr, tone_div, tone_en, busy, done, led
  );

  modport slave (
    output start, stop, loop_en, rom_data,
    input  rom_addr, tone_div, tone_en, busy, done, led
  );

endinterface

// File: rtl/note_div_lut.sv
// Combinational note decoder.
//   note     in  7-bit note code {oct, semi}
//   is_rest  out high for the rest code and for semitones 12..15
//   tone_div out half-period count BASE[semi] >> oct (0 for rests)
module note_div_lut
  import musicbox_pkg::*;
#(
  parameter int CLK_HZ = 25000000,
  parameter int DIV_W  = 20
) (
  input  logic [NOTE_W-1:0] note,
  output logic              is_rest,
  output logic [DIV_W-1:0]  tone_div
);

  localparam longint unsigned CLK = longint'(CLK_HZ);

  localparam logic [DIV_W-1:0] BASE [NUM_SEMIS] = '{
    DIV_W'(base_div(0, CLK)),  DIV_W'(base_div(1, CLK)),  DIV_W'(base_div(2, CLK)),
    DIV_W'(base_div(3, CLK)),  DIV_W'(base_div(4, CLK)),  DIV_W'(base_div(5, CLK)),
    DIV_W'(base_div(6, CLK)),  DIV_W'(base_div(7, CLK)),  DIV_W'(base_div(8, CLK)),
    DIV_W'(base_div(9, CLK)),  DIV_W'(base_div(10, CLK)), DIV_W'(base_div(11, CLK))
  };

  logic [OCT_W-1:0]  oct;
  logic [SEMI_W-1:0] semi;

  assign oct  = note[NOTE_W-1 -: OCT_W];
  assign semi = note[SEMI_W-1:0];

  // Higher octaves halve the period, so each octave step is one right shift.
  always_comb begin
    is_rest  = 1'b0;
    tone_div = '0;
    if (note == NOTE_REST || semi >= SEMI_W'(NUM_SEMIS)) begin
      is_rest = 1'b1;
    end else begin
      tone_div = BASE[semi] >> oct;
    end
  end

endmodule

// File: rtl/musicbox_sequencer.sv
// Song playback controller: walks the song ROM, decodes each entry into a
// tone divider and a duration, and times each note against a tempo tick.
//   clk, rst_n   clock and asynchronous active-low reset
//   bus.master   start/stop/loop_en controls, ROM address/data,
//                tone_div/tone_en to the tone generator, busy, done, led
module musicbox_sequencer
  import musicbox_pkg::*;
#(
  parameter int CLK_HZ      = 25000000,
  parameter int TICK_CYCLES = 1562500,
  parameter int ADDR_W      = 8,
  parameter int SONG_LEN    = 256,
  parameter int DIV_W       = 20
) (
  input logic        clk,
  input logic        rst_n,
  musicbox_if.master bus
);

  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [DIV_W-1:0]    tone_div_q, tone_div_d;
  logic                rest_q, rest_d;
  logic                multi_q, multi_d;
  logic [4:0]          beats_q, beats_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                led_q, led_d;
  logic                done_q, done_d;

  logic [NOTE_W-1:0]   entry_note;
  logic [DUR_W-1:0]    entry_dur;
  logic                lut_rest;
  logic [DIV_W-1:0]    lut_div;
  logic                tick_wrap;
  logic                last_unit;

  assign entry_note = bus.rom_data[NOTE_LSB +: NOTE_W];
  assign entry_dur  = bus.rom_data[DUR_LSB +: DUR_W];
  assign tick_wrap  = (tick_q == TICK_LAST);
  assign last_unit  = (beats_q == 5'd1);

  note_div_lut #(
    .CLK_HZ (CLK_HZ),
    .DIV_W  (DIV_W)
  ) u_lut (
    .note     (entry_note),
    .is_rest  (lut_rest),
    .tone_div (lut_div)
  );

  // State and counter registers; reset clears every output immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      tone_div_q <= '0;
      rest_q     <= 1'b0;
      multi_q    <= 1'b0;
      beats_q    <= '0;
      tick_q     <= '0;
      led_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      tone_div_q <= tone_div_d;
      rest_q     <= rest_d;
      multi_q    <= multi_d;
      beats_q    <= beats_d;
      tick_q     <= tick_d;
      led_q      <= led_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic. stop overrides everything, including a start in IDLE.
  // The last ROM address is treated as END, so rom_addr never wraps.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    tone_div_d = tone_div_q;
    rest_d     = rest_q;
    multi_d    = multi_q;
    beats_d    = beats_q;
    tick_d     = tick_q;
    led_d      = led_q;
    done_d     = 1'b0;

    if (bus.stop) begin
      state_d    = IDLE;
      rom_addr_d = '0;
      led_d      = 1'b0;
      beats_d    = '0;
      tick_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          rom_addr_d = '0;
          led_d      = 1'b0;
          if (bus.start) begin
            state_d = FETCH;
          end
        end
        FETCH: begin
          state_d = LOAD;
        end
        LOAD: begin
          if (entry_note == NOTE_END || rom_addr_q == ADDR_LAST) begin
            rom_addr_d = '0;
            if (bus.loop_en) begin
              state_d = FETCH;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
              led_d   = 1'b0;
            end
          end else begin
            // Rests leave the previous divider in place.
            if (!lut_rest) begin
              tone_div_d = lut_div;
            end
            rest_d  = lut_rest;
            beats_d = (entry_dur == '0) ? 5'd16 : {1'b0, entry_dur};
            multi_d = (entry_dur != 4'd1);
            tick_d  = '0;
            state_d = PLAY;
          end
        end
        PLAY: begin
          if (tick_wrap) begin
            tick_d  = '0;
            led_d   = ~led_q;
            beats_d = beats_q - 5'd1;
            if (last_unit) begin
              rom_addr_d = rom_addr_q + ADDR_W'(1);
              state_d    = FETCH;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Multi-unit notes go silent for their whole final unit (articulation gap);
  // single-unit notes only drop out on the closing tick.
  assign bus.tone_en  = (state_q == PLAY) && !rest_q &&
                        !(last_unit && (multi_q || tick_wrap));
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.led      = led_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.tone_div = tone_div_q;

endmodule

// File: tb/tb_musicbox_sequencer.sv
module tb_musicbox_sequencer;
  import musicbox_pkg::*;

  localparam int T        = 4;
  localparam int SONG_LEN = 4;

  typedef struct {
    logic        en;
    logic        busy;
    logic        done;
    logic        led;
    logic [7:0]  addr;
    logic [19:0] div;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [10:0] rom [SONG_LEN];

  exp_t expQ[$];
  logic mLed;
  logic [19:0] mDiv;
  int testsRun;
  int testsFailed;

  musicbox_if #(.ADDR_W(8), .DIV_W(20)) mbus ();

  musicbox_sequencer #(
    .CLK_HZ      (25000000),
    .TICK_CYCLES (T),
    .ADDR_W      (8),
    .SONG_LEN    (SONG_LEN),
    .DIV_W       (20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mbus)
  );

  // Song ROM with one cycle of read latency
  always_ff @(posedge clk) mbus.rom_data <= rom[mbus.rom_addr[1:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Independent reference divider values for the notes used by the songs
  function automatic logic [19:0] expDiv(input logic [6:0] nt);
    case (nt)
      7'h49:   return 20'd28409;
      7'h29:   return 20'd113636;
      7'h20:   return 20'd191112;
      7'h39:   return 20'd56818;
      7'h59:   return 20'd14204;
      default: return 20'd0;
    endcase
  endfunction

  task automatic pushCyc(input logic en, input logic busy, input logic done,
                         input logic led, input int addr, input logic [19:0] div);
    exp_t e;
    e.en = en; e.busy = busy; e.done = done; e.led = led;
    e.addr = 8'(addr); e.div = div;
    expQ.push_back(e);
  endtask

  // Expands the current ROM contents into the expected per-cycle outputs
  task automatic expandSong(input bit loopEn, input int passes);
    int a = 0;
    int left = passes;
    int d;
    logic [6:0] nt;
    bit isRest;
    bit on;
    forever begin
      pushCyc(1'b0, 1'b1, 1'b0, mLed, a, mDiv);
      pushCyc(1'b0, 1'b1, 1'b0, mLed, a, mDiv);
      nt = rom[a][6:0];
      if (nt == 7'h7F || a == SONG_LEN - 1) begin
        if (loopEn) begin
          left--;
          if (left == 0) return;
          a = 0;
        end else begin
          mLed = 1'b0;
          pushCyc(1'b0, 1'b0, 1'b1, 1'b0, 0, mDiv);
          pushCyc(1'b0, 1'b0, 1'b0, 1'b0, 0, mDiv);
          return;
        end
      end else begin
        d = (rom[a][10:7] == 4'd0) ? 16 : int'(rom[a][10:7]);
        isRest = (nt == 7'h00) || (nt[3:0] >= 4'd12);
        if (!isRest) mDiv = expDiv(nt);
        for (int u = 0; u < d; u++) begin
          for (int k = 0; k < T; k++) begin
            on = !isRest && ((d > 1 && u < d - 1) || (d == 1 && k < T - 1));
            pushCyc(on, 1'b1, 1'b0, mLed, a, mDiv);
          end
          mLed = ~mLed;
        end
        a++;
      end
    end
  endtask

  task automatic checkCycle(input exp_t e, input int i);
    checkOutput($sformatf("tone_en@%0d", i),  32'(mbus.tone_en),  32'(e.en));
    checkOutput($sformatf("busy@%0d", i),     32'(mbus.busy),     32'(e.busy));
    checkOutput($sformatf("done@%0d", i),     32'(mbus.done),     32'(e.done));
    checkOutput($sformatf("led@%0d", i),      32'(mbus.led),      32'(e.led));
    checkOutput($sformatf("rom_addr@%0d", i), 32'(mbus.rom_addr), 32'(e.addr));
    checkOutput($sformatf("tone_div@%0d", i), 32'(mbus.tone_div), 32'(e.div));
  endtask

  // mode 0: full song; mode 1: stop after 'keep' cycles (-1 = whole queue);
  // mode 2: truncate to 'keep' cycles and return mid-song
  task automatic applyStimulus(input int mode, input int keep, input int pokeStart);
    int n;
    int stopIdx;
    exp_t e;
    if (mode != 0 && keep >= 0) begin
      while (expQ.size() > keep) expQ.delete(expQ.size() - 1);
    end
    stopIdx = expQ.size() - 1;
    if (mode == 1) begin
      mLed = 1'b0;
      pushCyc(1'b0, 1'b0, 1'b0, 1'b0, 0, mDiv);
      pushCyc(1'b0, 1'b0, 1'b0, 1'b0, 0, mDiv);
    end
    @(negedge clk);
    mbus.start = 1'b1;
    n = expQ.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mbus.start = 1'b0;
      mbus.stop  = 1'b0;
      e = expQ.pop_front();
      checkCycle(e, i);
      if (mode == 1 && i == stopIdx) mbus.stop = 1'b1;
      if (i == pokeStart) mbus.start = 1'b1;
    end
    @(negedge clk);
    mbus.start = 1'b0;
    mbus.stop  = 1'b0;
  endtask

  task automatic loadRom(input logic [10:0] e0, input logic [10:0] e1,
                         input logic [10:0] e2, input logic [10:0] e3);
    rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    mLed = 1'b0;
    mDiv = 20'd0;
    rst_n = 1'b0;
    mbus.start = 1'b0;
    mbus.stop = 1'b0;
    mbus.loop_en = 1'b0;
    loadRom(11'h7F, 11'h7F, 11'h7F, 11'h7F);

    $display("[TB] reset values");
    repeat (3) @(negedge clk);
    checkCycle('{en: 1'b0, busy: 1'b0, done: 1'b0, led: 1'b0, addr: 8'd0, div: 20'd0}, -1);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single note then END");
    loadRom({4'd2, 7'h49}, {4'd0, 7'h7F}, 11'h7F, 11'h7F);
    expandSong(1'b0, 1);
    applyStimulus(0, -1, -1);

    $display("[TB] rest keeps divider, led toggles");
    loadRom({4'd1, 7'h00}, {4'd0, 7'h7F}, 11'h7F, 11'h7F);
    expandSong(1'b0, 1);
    applyStimulus(0, -1, -1);

    $display("[TB] looping two-note song");
    loadRom({4'd1, 7'h29}, {4'd2, 7'h20}, {4'd0, 7'h7F}, 11'h7F);
    mbus.loop_en = 1'b1;
    expandSong(1'b1, 2);
    applyStimulus(1, -1, -1);
    mbus.loop_en = 1'b0;

    $display("[TB] stop mid-note, start while busy ignored");
    loadRom({4'd2, 7'h49}, {4'd0, 7'h7F}, 11'h7F, 11'h7F);
    expandSong(1'b0, 1);
    applyStimulus(1, 7, 3);

    $display("[TB] start and stop together in IDLE");
    @(negedge clk);
    mbus.start = 1'b1;
    mbus.stop  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mbus.start = 1'b0;
      mbus.stop  = 1'b0;
      checkOutput($sformatf("idle_busy@%0d", i),    32'(mbus.busy),     32'd0);
      checkOutput($sformatf("idle_tone_en@%0d", i), 32'(mbus.tone_en),  32'd0);
      checkOutput($sformatf("idle_addr@%0d", i),    32'(mbus.rom_addr), 32'd0);
      checkOutput($sformatf("idle_done@%0d", i),    32'(mbus.done),     32'd0);
    end

    $display("[TB] song fills ROM, dur=0 note");
    loadRom({4'd0, 7'h39}, {4'd1, 7'h1C}, {4'd1, 7'h59}, {4'd3, 7'h49});
    expandSong(1'b0, 1);
    applyStimulus(0, -1, -1);

    $display("[TB] asynchronous reset mid-note");
    loadRom({4'd3, 7'h49}, {4'd0, 7'h7F}, 11'h7F, 11'h7F);
    expandSong(1'b0, 1);
    applyStimulus(2, 8, -1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_tone_en", 32'(mbus.tone_en),  32'd0);
    checkOutput("rst_busy",    32'(mbus.busy),     32'd0);
    checkOutput("rst_led",     32'(mbus.led),      32'd0);
    checkOutput("rst_addr",    32'(mbus.rom_addr), 32'd0);
    checkOutput("rst_div",     32'(mbus.tone_div), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mLed = 1'b0;
    mDiv = 20'd0;
    expQ.delete();
    expandSong(1'b0, 1);
    applyStimulus(0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
